dpram_fifo_ctrl: RTL and testbench
==================================

DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
- REQ-001: Parameter DATA_WIDTH, default 8: width of each stored word.
- REQ-002: Parameter ADDR_WIDTH, default 4: address width; depth = 2**ADDR_WIDTH (16).
- REQ-003: CLK  input  1: single clock; all state updates on rising edge.
- REQ-004: SR_N  input  1: reset, synchronous, active-low.
- REQ-005: WR_EN  input  1: write request.
- REQ-006: WR_DATA  input  DATA_WIDTH: write word.
- REQ-007: RD_EN  input  1: read request.
- REQ-008: RD_DATA  output  DATA_WIDTH: registered read word.
- REQ-009: RD_VALID  output  1: RD_DATA holds a newly read word this cycle.
- REQ-010: FULL  output  1: occupancy == depth.
- REQ-011: EMPTY  output  1: occupancy == 0.
- REQ-012: COUNT  output  ADDR_WIDTH+1: current occupancy, 0..depth.
- REQ-013: OVERFLOW  output  1: sticky; rejected write seen.
- REQ-014: UNDERFLOW  output  1: sticky; rejected read seen.

Function
- REQ-015: Storage SHALL be an internal inferred simple dual-port RAM (one write port, one registered read port), depth 2**ADDR_WIDTH.
- REQ-016: Write accepted when WR_EN=1 and (FULL=0 or read accepted in the same cycle); accepted write stores WR_DATA at wptr, wptr increments modulo depth.
- REQ-017: Read accepted when RD_EN=1 and EMPTY=0; no first-word fall-through; a write in the same cycle while EMPTY=1 does not make the read acceptable.
- REQ-018: Accepted read: RD_DATA = mem[rptr] and RD_VALID=1 on the next edge (latency 1); rptr increments modulo depth; RD_VALID=0 in all other cycles.
- REQ-019: RD_DATA SHALL hold its last value when no read is accepted.
- REQ-020: COUNT +1 on write-only accept, -1 on read-only accept, unchanged on both or neither; FULL/EMPTY derived from registered COUNT, valid in the same cycle as COUNT.
- REQ-021: Pointers wrap from depth-1 to 0 with no lost or duplicated words.
- REQ-022: Simultaneous accepted read and write to the same address (COUNT==depth, wptr==rptr) SHALL return the old stored word (read-before-write).
- REQ-023: WR_EN=1 with FULL=1 and no accepted read: write dropped, state unchanged, OVERFLOW set to 1 and held.
- REQ-024: RD_EN=1 with EMPTY=1: read dropped, RD_VALID=0, UNDERFLOW set to 1 and held.

Reset
- REQ-025: SR_N=0 at a rising edge: wptr=0, rptr=0, COUNT=0, EMPTY=1, FULL=0, RD_VALID=0, RD_DATA=0, OVERFLOW=0, UNDERFLOW=0; RAM contents undefined and not cleared.
- REQ-026: Reset overrides WR_EN/RD_EN in the same cycle; reset mid-operation discards all words and any pending read.
- REQ-027: The first access is accepted in the first cycle with SR_N=1.

Configuration
- REQ-028: Macro DPRAM_FIFO_OREG_EN defined: one extra output register stage; RD_DATA/RD_VALID latency 2 from accepted read; extra stage reset to 0 by SR_N; COUNT/FULL/EMPTY timing unchanged.
- REQ-029: Macro not defined: latency exactly 1 per REQ-018; no extra stage.

Verification
- REQ-030: Reset, write 0x11,0x22,0x33, then 3 reads -> RD_DATA 0x11,0x22,0x33 with RD_VALID one cycle after each RD_EN (two with OREG_EN); COUNT 3->0; EMPTY=1 at end.
- REQ-031: Write 16 words 0x00..0x0F -> FULL=1, COUNT=16; 17th write 0xAA -> dropped, OVERFLOW=1; 16 reads return 0x00..0x0F, no 0xAA.
- REQ-032: RD_EN while EMPTY after reset -> RD_VALID=0, UNDERFLOW=1, COUNT=0; WR_EN+RD_EN together while empty -> write accepted, COUNT=1, RD_VALID=0.
- REQ-033: FULL, simultaneous WR_EN(0x55)+RD_EN -> both accepted, COUNT stays 16, RD_DATA = oldest word; 0x55 read last after 15 further reads.
- REQ-034: 40 cycles of interleaved write/read across pointer wraparound -> output sequence equals input sequence in order, COUNT matches scoreboard every cycle.
- REQ-035: Assert SR_N=0 with COUNT=5 and RD_EN=1 -> next cycle COUNT=0, EMPTY=1, RD_VALID=0, OVERFLOW=UNDERFLOW=0.

Source files
------------

// File: rtl/dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dpram_fifo_ctrl
//  Purpose  : Synchronous FIFO built on an inferred simple dual-port RAM
//             (one write port, one registered read port). No first-word
//             fall-through: read data appears one cycle after an accepted
//             read, or two cycles when the optional output register is on.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   single clock, rising edge
//    sr_n       in   synchronous active-low reset
//    wr_en      in   write request
//    wr_data    in   [DATA_WIDTH-1:0] write word
//    rd_en      in   read request
//    rd_data    out  [DATA_WIDTH-1:0] registered read word (holds when idle)
//    rd_valid   out  rd_data carries a newly read word this cycle
//    full       out  occupancy == depth
//    empty      out  occupancy == 0
//    count      out  [ADDR_WIDTH:0] occupancy, 0..depth
//    overflow   out  sticky: a write was rejected
//    underflow  out  sticky: a read was rejected
//  Configuration macro
//    DPRAM_FIFO_OREG_EN  adds one output register stage on rd_data/rd_valid
// ============================================================================
module dpram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  sr_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   occ;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ram_valid;
  logic                  ovf_flag;
  logic                  udf_flag;
  logic                  rd_acc;
  logic                  wr_acc;

  assign full  = (occ == DEPTH_CNT);
  assign empty = (occ == '0);
  assign count = occ;

  // A read is judged on registered occupancy only, so a same-cycle write into
  // an empty FIFO never makes it readable. A write into a full FIFO is allowed
  // when a read frees a slot in the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  // RAM write port. Reset blocks the write; contents are never cleared.
  always_ff @(posedge clk) begin
    if (sr_n && wr_acc) begin
      mem[wptr] <= wr_data;
    end
  end

  // Registered read port. When full with a simultaneous read and write,
  // wptr == rptr and the non-blocking update yields the old word
  // (read-before-write).
  always_ff @(posedge clk) begin
    if (!sr_n) begin
      ram_data  <= '0;
      ram_valid <= 1'b0;
    end else begin
      ram_valid <= rd_acc;
      if (rd_acc) begin
        ram_data <= mem[rptr];
      end
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (!sr_n) begin
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      ovf_flag <= 1'b0;
      udf_flag <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rptr <= rptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (wr_en && !wr_acc) begin
        ovf_flag <= 1'b1;
      end
      if (rd_en && empty) begin
        udf_flag <= 1'b1;
      end
    end
  end

  assign overflow  = ovf_flag;
  assign underflow = udf_flag;

`ifdef DPRAM_FIFO_OREG_EN
  // Extra output stage; it simply follows the RAM output register, so the
  // hold-last-value behaviour carries through unchanged.
  logic [DATA_WIDTH-1:0] oreg_data;
  logic                  oreg_valid;

  always_ff @(posedge clk) begin
    if (!sr_n) begin
      oreg_data  <= '0;
      oreg_valid <= 1'b0;
    end else begin
      oreg_data  <= ram_data;
      oreg_valid <= ram_valid;
    end
  end

  assign rd_data  = oreg_data;
  assign rd_valid = oreg_valid;
`else
  assign rd_data  = ram_data;
  assign rd_valid = ram_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dpram_fifo_ctrl
//  Purpose  : Self-checking bench for dpram_fifo_ctrl (default parameters).
//             A queue-based FIFO model is compared against the DUT outputs
//             every cycle; directed sequences add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_fifo_ctrl;

`ifdef DPRAM_FIFO_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       sr_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  dpram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk       (clk),
    .sr_n      (sr_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] q[$];
  logic       m_v [LAT];
  logic [7:0] m_d [LAT];
  bit         m_ovf, m_udf;
  bit         started = 0;
  bit         rd_ok, wr_ok;
  logic [7:0] popped;
  logic [7:0] out_log[$];

  always @(posedge clk) begin
    if (!sr_n) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
      for (int i = 0; i < LAT; i++) begin
        m_v[i] = 1'b0;
        m_d[i] = 8'h00;
      end
    end else begin
      rd_ok = rd_en && (q.size() != 0);
      wr_ok = wr_en && ((q.size() < 16) || rd_ok);
      if (wr_en && !wr_ok) m_ovf = 1;
      if (rd_en && !rd_ok) m_udf = 1;
      popped = 8'h00;
      if (rd_ok) popped = q.pop_front();
      if (wr_ok) q.push_back(wr_data);
      for (int i = LAT - 1; i > 0; i--) begin
        m_v[i] = m_v[i-1];
        m_d[i] = m_d[i-1];
      end
      m_v[0] = rd_ok;
      if (rd_ok) m_d[0] = popped;
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("count",     32'(count),     32'(q.size()));
      chk("full",      32'(full),      32'(q.size() == 16));
      chk("empty",     32'(empty),     32'(q.size() == 0));
      chk("rd_valid",  32'(rd_valid),  32'(m_v[LAT-1]));
      chk("rd_data",   32'(rd_data),   32'(m_d[LAT-1]));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_udf));
      if (rd_valid) out_log.push_back(rd_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic we, input logic [7:0] wd, input logic re,
                      input logic rst_n = 1'b1);
    sr_n    = rst_n;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  logic [7:0] exp_seq[$];

  initial begin
    sr_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;

    // Reset state
    do_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_flags", 32'({overflow, underflow}), 0);

    // Basic write/read, first access right after reset
    out_log.delete();
    step(1'b1, 8'h11, 1'b0);
    chk("first_write_count", 32'(count), 1);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    chk("three_count", 32'(count), 3);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    idle(LAT);
    chk("basic_log_size", 32'(out_log.size()), 3);
    if (out_log.size() == 3) begin
      chk("basic_rd0", 32'(out_log[0]), 32'h11);
      chk("basic_rd1", 32'(out_log[1]), 32'h22);
      chk("basic_rd2", 32'(out_log[2]), 32'h33);
    end
    chk("basic_end_empty", 32'(empty), 1);
    chk("basic_end_count", 32'(count), 0);

    // Underflow, then simultaneous write+read while empty
    do_reset();
    out_log.delete();
    step(1'b0, 8'h00, 1'b1);
    chk("udf_flag", 32'(underflow), 1);
    chk("udf_count", 32'(count), 0);
    step(1'b1, 8'h77, 1'b1);
    chk("empty_wr_rd_count", 32'(count), 1);
    idle(LAT);
    chk("empty_wr_rd_no_valid", 32'(out_log.size()), 0);
    step(1'b0, 8'h00, 1'b1);
    idle(LAT);
    chk("empty_wr_rd_data", 32'(out_log.size() == 1 ? out_log[0] : 8'hxx), 32'h77);

    // Fill, overflow, drain
    do_reset();
    out_log.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    step(1'b1, 8'hAA, 1'b0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    idle(LAT);
    chk("drain_log_size", 32'(out_log.size()), 16);
    for (int i = 0; i < out_log.size() && i < 16; i++)
      chk("drain_word", 32'(out_log[i]), 32'(i));
    chk("drain_empty", 32'(empty), 1);

    // Full with simultaneous write+read (read-before-write)
    do_reset();
    out_log.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b1, 8'h55, 1'b1);
    chk("full_rw_count", 32'(count), 16);
    idle(LAT);
    chk("full_rw_oldest", 32'(out_log.size() == 1 ? out_log[0] : 8'hxx), 32'h80);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    idle(LAT);
    chk("full_rw_log_size", 32'(out_log.size()), 17);
    chk("full_rw_last", 32'(out_log.size() == 17 ? out_log[16] : 8'hxx), 32'h55);

    // Interleaved traffic across pointer wraparound
    do_reset();
    out_log.delete();
    exp_seq.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h30 + i), 1'b0);
      exp_seq.push_back(8'(8'h30 + i));
    end
    for (int i = 0; i < 40; i++) begin
      step((i % 4) != 3, 8'(8'h40 + i), (i % 3) != 0);
      if ((i % 4) != 3) exp_seq.push_back(8'(8'h40 + i));
    end
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    idle(LAT);
    chk("wrap_log_size", 32'(out_log.size()), 40);
    for (int i = 0; i < out_log.size() && i < exp_seq.size(); i++)
      chk("wrap_word", 32'(out_log[i]), 32'(exp_seq[i]));

    // Reset mid-operation with a pending read request
    do_reset();
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1);
    chk("pre_rst_count", 32'(count), 5);
    chk("pre_rst_flags", 32'({overflow, underflow}), 32'h3);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_rd_valid", 32'(rd_valid), 0);
    chk("mid_rst_flags", 32'({overflow, underflow}), 0);
    idle(LAT);
    chk("mid_rst_no_late_valid", 32'(rd_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
